// File: rtl/dmem_agu.sv
// dmem_agu: single-port-per-direction data memory with built-in address
// generation for the DSP datapath. The write and read pointers each walk a
// circular buffer (base, length, stride) and advance on every access.
//
// Optional build macro: DMEM_AGU_BITREV_EN. When it is defined, bit-reversed
// read addressing is available for FFT output reordering.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   cfg_load            load a new base/len/stride/bitrev this cycle
//   cfg_base            physical base address of the circular buffer
//   cfg_len             buffer length in words, 1..DEPTH
//   cfg_stride          pointer increment per access, 0..cfg_len-1
//   cfg_bitrev          bit-reversed read addressing (macro builds only)
//   cfg_err             one-cycle pulse when a cfg_load was rejected
//   wr_en, wr_data      write at wr_ptr, then advance the write offset
//   rd_en               read at rd_ptr, then advance the read offset
//   rd_data, rd_valid   registered read data (1-cycle latency) and strobe
//   wr_wrap, rd_wrap    pulse when that access wrapped the offset past len
//   wr_ptr, rd_ptr      current physical addresses (combinational)
module dmem_agu #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_load,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [ADDR_W:0]   cfg_len,
    input  logic [ADDR_W:0]   cfg_stride,
    input  logic              cfg_bitrev,
    output logic              cfg_err,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              wr_wrap,
    output logic              rd_wrap,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic [ADDR_W-1:0] rd_ptr
);

    localparam int unsigned    DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] base_q,   base_d;
    logic [ADDR_W:0]   len_q,    len_d;
    logic [ADDR_W:0]   stride_q, stride_d;
    logic [ADDR_W:0]   wr_off_q, wr_off_d;
    logic [ADDR_W:0]   rd_off_q, rd_off_d;
    logic              rd_valid_q, rd_valid_d;
    logic              cfg_err_q,  cfg_err_d;
    logic              wr_wrap_q,  wr_wrap_d;
    logic              rd_wrap_q,  rd_wrap_d;
    logic [DATA_W-1:0] rd_data_q;

    logic              cfg_ok;
    logic              wr_acc, rd_acc;
    // Offsets stay below DEPTH and stride below len, so off + stride
    // always fits in ADDR_W+1 bits.
    logic [ADDR_W:0]   wr_n, rd_n;
    logic              wr_hit, rd_hit;
    logic [ADDR_W-1:0] rd_lin_off;

`ifdef DMEM_AGU_BITREV_EN
    logic              bitrev_q, bitrev_d;
    logic [ADDR_W-1:0] rev_full, rev_off;
    int unsigned       rev_bits;

    // Reverse all ADDR_W bits, then shift down so only the low log2(len)
    // bits of the offset take part in the reversal.
    always_comb begin
        rev_bits = 0;
        for (int unsigned i = 0; i <= ADDR_W; i++) begin
            if (len_q[i]) rev_bits = i;
        end
        rev_full = '0;
        for (int unsigned i = 0; i < ADDR_W; i++) begin
            rev_full[i] = rd_off_q[ADDR_W-1-i];
        end
        rev_off = rev_full >> (ADDR_W - rev_bits);
    end

    assign rd_lin_off = bitrev_q ? rev_off : rd_off_q[ADDR_W-1:0];
`else
    logic unused_cfg_bitrev;
    assign unused_cfg_bitrev = cfg_bitrev;
    assign rd_lin_off        = rd_off_q[ADDR_W-1:0];
`endif

    // Truncation to ADDR_W bits wraps the buffer across the top of memory.
    assign wr_ptr = base_q + wr_off_q[ADDR_W-1:0];
    assign rd_ptr = base_q + rd_lin_off;

    assign wr_acc = wr_en && !cfg_load;
    assign rd_acc = rd_en && !cfg_load;

    always_comb begin
        cfg_ok = (cfg_len != '0) && (cfg_len <= DEPTH_W) && (cfg_stride < cfg_len);
`ifdef DMEM_AGU_BITREV_EN
        if (cfg_bitrev && !((cfg_len >= (ADDR_W + 1)'(2)) &&
                            ((cfg_len & (cfg_len - 1'b1)) == '0))) begin
            cfg_ok = 1'b0;
        end
`endif

        wr_n   = wr_off_q + stride_q;
        rd_n   = rd_off_q + stride_q;
        wr_hit = wr_n >= len_q;
        rd_hit = rd_n >= len_q;

        base_d     = base_q;
        len_d      = len_q;
        stride_d   = stride_q;
        wr_off_d   = wr_off_q;
        rd_off_d   = rd_off_q;
`ifdef DMEM_AGU_BITREV_EN
        bitrev_d   = bitrev_q;
`endif
        rd_valid_d = rd_acc;
        cfg_err_d  = cfg_load && !cfg_ok;
        wr_wrap_d  = wr_acc && wr_hit;
        rd_wrap_d  = rd_acc && rd_hit;

        if (cfg_load) begin
            if (cfg_ok) begin
                base_d   = cfg_base;
                len_d    = cfg_len;
                stride_d = cfg_stride;
                wr_off_d = '0;
                rd_off_d = '0;
`ifdef DMEM_AGU_BITREV_EN
                bitrev_d = cfg_bitrev;
`endif
            end
        end else begin
            if (wr_en) wr_off_d = wr_hit ? (wr_n - len_q) : wr_n;
            if (rd_en) rd_off_d = rd_hit ? (rd_n - len_q) : rd_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            base_q     <= '0;
            len_q      <= DEPTH_W;
            stride_q   <= (ADDR_W + 1)'(1);
            wr_off_q   <= '0;
            rd_off_q   <= '0;
`ifdef DMEM_AGU_BITREV_EN
            bitrev_q   <= 1'b0;
`endif
            rd_valid_q <= 1'b0;
            cfg_err_q  <= 1'b0;
            wr_wrap_q  <= 1'b0;
            rd_wrap_q  <= 1'b0;
        end else begin
            base_q     <= base_d;
            len_q      <= len_d;
            stride_q   <= stride_d;
            wr_off_q   <= wr_off_d;
            rd_off_q   <= rd_off_d;
`ifdef DMEM_AGU_BITREV_EN
            bitrev_q   <= bitrev_d;
`endif
            rd_valid_q <= rd_valid_d;
            cfg_err_q  <= cfg_err_d;
            wr_wrap_q  <= wr_wrap_d;
            rd_wrap_q  <= rd_wrap_d;
        end
    end

    // Storage array is not reset; non-blocking read/write gives read-first
    // behaviour on a same-address collision.
    always_ff @(posedge clk) begin
        if (wr_acc && !rst) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (rd_acc) begin
            rd_data_q <= mem[rd_ptr];
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign cfg_err  = cfg_err_q;
    assign wr_wrap  = wr_wrap_q;
    assign rd_wrap  = rd_wrap_q;

endmodule

// File: tb/tb_dmem_agu.sv
// Directed bench for dmem_agu with DATA_W=32, ADDR_W=10.
module tb_dmem_agu;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_load;
    logic [9:0]  cfg_base;
    logic [10:0] cfg_len;
    logic [10:0] cfg_stride;
    logic        cfg_bitrev;
    logic        cfg_err;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        rd_en;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        wr_wrap;
    logic        rd_wrap;
    logic [9:0]  wr_ptr;
    logic [9:0]  rd_ptr;

    int n_cmp = 0;
    int n_bad = 0;

    dmem_agu #(.DATA_W(32), .ADDR_W(10)) dut (
        .clk(clk), .rst(rst),
        .cfg_load(cfg_load), .cfg_base(cfg_base), .cfg_len(cfg_len),
        .cfg_stride(cfg_stride), .cfg_bitrev(cfg_bitrev), .cfg_err(cfg_err),
        .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en), .rd_data(rd_data),
        .rd_valid(rd_valid), .wr_wrap(wr_wrap), .rd_wrap(rd_wrap),
        .wr_ptr(wr_ptr), .rd_ptr(rd_ptr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        cfg_load;
        logic [9:0]  base;
        logic [10:0] len;
        logic [10:0] stride;
        logic        rd_en;
        logic        exp_valid;
        logic [31:0] exp_data;
        logic        exp_rd_wrap;
        logic        exp_err;
        logic [9:0]  exp_rd_ptr;
        logic [9:0]  exp_wr_ptr;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cfg_load = 1'b0; cfg_base = '0; cfg_len = '0; cfg_stride = '0;
        cfg_bitrev = 1'b0; wr_en = 1'b0; wr_data = '0; rd_en = 1'b0;
    endtask

    task automatic load(input logic [9:0] b, input logic [10:0] l,
                        input logic [10:0] s, input logic br);
        cfg_load = 1'b1; cfg_base = b; cfg_len = l; cfg_stride = s; cfg_bitrev = br;
    endtask

    logic [31:0] t2_exp [8];
    int          br_ord [8];
    logic        exp_br_err;

    initial begin
        // Case 3/4 table: base 1020, len 6, stride 4 over the contents
        // written by case 2 (1020=A8 1021=A9 1022=A2 1023=A3 0=A4 1=A5).
        tbl[0]  = '{1'b1, 10'd1020, 11'd6, 11'd4, 1'b0, 1'b0, 32'hA7, 1'b0, 1'b0, 10'd1020, 10'd1020};
        tbl[1]  = '{1'b0, 10'd0,    11'd0, 11'd0, 1'b1, 1'b1, 32'hA8, 1'b0, 1'b0, 10'd0,    10'd1020};
        tbl[2]  = '{1'b0, 10'd0,    11'd0, 11'd0, 1'b1, 1'b1, 32'hA4, 1'b1, 1'b0, 10'd1022, 10'd1020};
        tbl[3]  = '{1'b0, 10'd0,    11'd0, 11'd0, 1'b1, 1'b1, 32'hA2, 1'b1, 1'b0, 10'd1020, 10'd1020};
        tbl[4]  = '{1'b0, 10'd0,    11'd0, 11'd0, 1'b1, 1'b1, 32'hA8, 1'b0, 1'b0, 10'd0,    10'd1020};
        tbl[5]  = '{1'b0, 10'd0,    11'd0, 11'd0, 1'b1, 1'b1, 32'hA4, 1'b1, 1'b0, 10'd1022, 10'd1020};
        tbl[6]  = '{1'b0, 10'd0,    11'd0, 11'd0, 1'b1, 1'b1, 32'hA2, 1'b1, 1'b0, 10'd1020, 10'd1020};
        tbl[7]  = '{1'b1, 10'd5,    11'd5, 11'd5, 1'b1, 1'b0, 32'hA2, 1'b0, 1'b1, 10'd1020, 10'd1020};
        tbl[8]  = '{1'b0, 10'd0,    11'd0, 11'd0, 1'b0, 1'b0, 32'hA2, 1'b0, 1'b0, 10'd1020, 10'd1020};
        tbl[9]  = '{1'b0, 10'd0,    11'd0, 11'd0, 1'b1, 1'b1, 32'hA8, 1'b0, 1'b0, 10'd0,    10'd1020};
        tbl[10] = '{1'b1, 10'd0,    11'd0, 11'd0, 1'b0, 1'b0, 32'hA8, 1'b0, 1'b1, 10'd0,    10'd1020};
        tbl[11] = '{1'b0, 10'd0,    11'd0, 11'd0, 1'b0, 1'b0, 32'hA8, 1'b0, 1'b0, 10'd0,    10'd1020};

        t2_exp = '{32'hA8, 32'hA9, 32'hA2, 32'hA3, 32'hA4, 32'hA5, 32'hA6, 32'hA7};
`ifdef DMEM_AGU_BITREV_EN
        br_ord     = '{0, 4, 2, 6, 1, 5, 3, 7};
        exp_br_err = 1'b1;
`else
        br_ord     = '{0, 1, 2, 3, 4, 5, 6, 7};
        exp_br_err = 1'b0;
`endif

        idle();
        rst = 1'b1;
        repeat (2) cyc();
        rst = 1'b0;
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_cfg_err", cfg_err, 0);
        chk("rst_wr_wrap", wr_wrap, 0);
        chk("rst_rd_wrap", rd_wrap, 0);
        chk("rst_wr_ptr", wr_ptr, 0);
        chk("rst_rd_ptr", rd_ptr, 0);

        // Case 1: fill and drain the whole memory with the reset config.
        for (int i = 0; i < 1024; i++) begin
            wr_en = 1'b1; wr_data = 32'(i);
            cyc();
            chk("c1_wr_wrap", wr_wrap, (i == 1023) ? 1 : 0);
            chk("c1_wr_ptr", wr_ptr, 32'((i + 1) % 1024));
        end
        wr_en = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            rd_en = 1'b1;
            cyc();
            chk("c1_rd_valid", rd_valid, 1);
            chk("c1_rd_data", rd_data, 32'(i));
            chk("c1_rd_wrap", rd_wrap, (i == 1023) ? 1 : 0);
        end
        rd_en = 1'b0;
        cyc();
        chk("c1_valid_drop", rd_valid, 0);
        chk("c1_data_hold", rd_data, 32'd1023);

        // Case 2: circular buffer straddling the top of memory.
        load(10'd1020, 11'd8, 11'd1, 1'b0);
        cyc();
        idle();
        chk("c2_cfg_err", cfg_err, 0);
        chk("c2_wr_ptr0", wr_ptr, 32'd1020);
        chk("c2_rd_ptr0", rd_ptr, 32'd1020);
        for (int i = 0; i < 10; i++) begin
            wr_en = 1'b1; wr_data = 32'hA0 + 32'(i);
            cyc();
            chk("c2_wr_wrap", wr_wrap, (i == 7) ? 1 : 0);
            chk("c2_wr_ptr", wr_ptr, 32'((1020 + (i + 1) % 8) % 1024));
        end
        wr_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rd_en = 1'b1;
            cyc();
            chk("c2_rd_valid", rd_valid, 1);
            chk("c2_rd_data", rd_data, t2_exp[i]);
            chk("c2_rd_ptr", rd_ptr, 32'((1020 + (i + 1) % 8) % 1024));
        end
        rd_en = 1'b0;

        // Cases 3/4: stride wrap and rejected configurations.
        for (int v = 0; v < 12; v++) begin
            idle();
            cfg_load = tbl[v].cfg_load; cfg_base = tbl[v].base;
            cfg_len = tbl[v].len; cfg_stride = tbl[v].stride; rd_en = tbl[v].rd_en;
            cyc();
            chk($sformatf("tbl%0d_rd_valid", v), rd_valid, tbl[v].exp_valid);
            chk($sformatf("tbl%0d_rd_data", v), rd_data, tbl[v].exp_data);
            chk($sformatf("tbl%0d_rd_wrap", v), rd_wrap, tbl[v].exp_rd_wrap);
            chk($sformatf("tbl%0d_cfg_err", v), cfg_err, tbl[v].exp_err);
            chk($sformatf("tbl%0d_rd_ptr", v), rd_ptr, tbl[v].exp_rd_ptr);
            chk($sformatf("tbl%0d_wr_ptr", v), wr_ptr, tbl[v].exp_wr_ptr);
            chk($sformatf("tbl%0d_wr_wrap", v), wr_wrap, 0);
        end
        idle();

        // Case 5a: stride 0, same-address read/write collision.
        load(10'd0, 11'd1024, 11'd0, 1'b0);
        cyc();
        idle();
        chk("c5_cfg_err", cfg_err, 0);
        wr_en = 1'b1; wr_data = 32'h11;
        cyc();
        chk("c5_wr_ptr_hold", wr_ptr, 0);
        wr_data = 32'h22; rd_en = 1'b1;
        cyc();
        chk("c5_rw_valid", rd_valid, 1);
        chk("c5_rw_old", rd_data, 32'h11);
        chk("c5_rd_ptr_hold", rd_ptr, 0);
        wr_en = 1'b0;
        cyc();
        chk("c5_rw_new", rd_data, 32'h22);
        rd_en = 1'b0;

        // Case 5b: cfg_load drops a concurrent write and read.
        load(10'd0, 11'd1024, 11'd1, 1'b0);
        cyc();
        idle();
        wr_en = 1'b1; wr_data = 32'h33;
        cyc();
        chk("c5_wr_ptr_adv", wr_ptr, 1);
        load(10'd0, 11'd1024, 11'd1, 1'b0);
        wr_en = 1'b1; wr_data = 32'h44; rd_en = 1'b1;
        cyc();
        idle();
        chk("c5_ld_wr_ptr", wr_ptr, 0);
        chk("c5_ld_rd_ptr", rd_ptr, 0);
        chk("c5_ld_valid", rd_valid, 0);
        rd_en = 1'b1;
        cyc();
        chk("c5_mem0", rd_data, 32'h33);
        cyc();
        chk("c5_mem1_kept", rd_data, 32'hA5);
        cyc();
        chk("c5_pre_rst_valid", rd_valid, 1);
        chk("c5_pre_rst_data", rd_data, 32'hA6);

        // Case 5c: reset beats an in-flight read.
        rst = 1'b1;
        cyc();
        rst = 1'b0; rd_en = 1'b0;
        chk("c5_rst_valid", rd_valid, 0);
        chk("c5_rst_data", rd_data, 0);
        chk("c5_rst_rd_ptr", rd_ptr, 0);
        chk("c5_rst_wr_ptr", wr_ptr, 0);

        // Case 6: bit-reversed reads (linear order without the macro).
        load(10'd0, 11'd8, 11'd1, 1'b1);
        cyc();
        idle();
        chk("c6_cfg_err", cfg_err, 0);
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_data = 32'h100 + 32'(i);
            cyc();
        end
        wr_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rd_en = 1'b1;
            cyc();
            chk("c6_rd_data", rd_data, 32'h100 + 32'(br_ord[i]));
            chk("c6_rd_wrap", rd_wrap, (i == 7) ? 1 : 0);
        end
        rd_en = 1'b0;
        load(10'd0, 11'd6, 11'd1, 1'b1);
        cyc();
        idle();
        chk("c6_len6_err", cfg_err, 32'(exp_br_err));
        cyc();
        chk("c6_err_clear", cfg_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
